// File: rtl/vthernet_rx_frame_buffer.sv
// GMII receive path: strips preamble/SFD, filters on destination MAC and queues frames
// in a NUM_SLOTS ring read by software. Optional FCS checking: VTHERNET_RX_CRC_CHECK_EN.
module vthernet_rx_frame_buffer #(
    parameter int NUM_SLOTS   = 4,
    parameter int SLOT_ADDR_W = 11,
    parameter int MAX_LEN     = 1522
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RX_DV,
    input  logic [7:0]             RXD,
    input  logic                   RX_ER,
    input  logic [47:0]            mac_addr,
    input  logic                   promisc,
    input  logic [SLOT_ADDR_W-1:0] rd_addr,
    output logic [7:0]             rd_data,
    output logic [SLOT_ADDR_W-1:0] head_len,
    output logic [3:0]             head_status,
    output logic                   frame_pending,
    input  logic                   frame_release,
    output logic                   rx_irq,
    output logic [15:0]            drop_count
);
    localparam int PTR_W = $clog2(NUM_SLOTS);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [SLOT_ADDR_W-1:0] LEN_MAX = SLOT_ADDR_W'(MAX_LEN);

    typedef enum logic [2:0] {
        S_DROP,
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_COMMIT
    } state_t;

    state_t state, state_next;

    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [SLOT_ADDR_W-1:0] byte_cnt;
    logic [47:0]            dest;
    logic                   flag_er, flag_long, crc_err;
    logic                   full, accept, start_frame, overflow_drop, commit_ok, do_release;
    logic [3:0]             status_now;

    logic [7:0]             mem         [NUM_SLOTS * (2**SLOT_ADDR_W)];
    logic [SLOT_ADDR_W-1:0] meta_len    [NUM_SLOTS];
    logic [3:0]             meta_status [NUM_SLOTS];

    assign full          = (count == CNT_W'(NUM_SLOTS));
    assign frame_pending = (count != '0);
    assign rx_irq        = frame_pending;
    assign do_release    = frame_release && frame_pending;
    assign accept        = (byte_cnt >= SLOT_ADDR_W'(6)) &&
                           ((dest == mac_addr) || (dest == '1) || promisc);
    assign status_now    = {crc_err, flag_long, (byte_cnt < SLOT_ADDR_W'(64)), flag_er};

    always_ff @(posedge clk) begin
        if (rst) state <= S_DROP;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        start_frame   = 1'b0;
        overflow_drop = 1'b0;
        commit_ok     = 1'b0;
        case (state)
            S_DROP: if (!RX_DV) state_next = S_IDLE;
            S_IDLE: if (RX_DV) state_next = (RXD == 8'h55) ? S_PREAMBLE : S_DROP;
            S_PREAMBLE: begin
                if (RX_DV && RXD == 8'h55) begin
                    state_next = S_PREAMBLE;
                end else if (RX_DV && RXD == 8'hD5) begin
                    // The slot is reserved here, so a commit can never find the ring full.
                    if (full) begin
                        overflow_drop = 1'b1;
                        state_next    = S_DROP;
                    end else begin
                        start_frame = 1'b1;
                        state_next  = S_DATA;
                    end
                end else begin
                    state_next = S_DROP;
                end
            end
            S_DATA: if (!RX_DV) state_next = S_COMMIT;
            S_COMMIT: begin
                commit_ok  = accept;
                state_next = S_IDLE;
            end
            default: state_next = S_DROP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            dest       <= '0;
            flag_er    <= 1'b0;
            flag_long  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
        end else begin
            if (start_frame) begin
                byte_cnt  <= '0;
                flag_er   <= 1'b0;
                flag_long <= 1'b0;
            end
            if (state == S_DATA) begin
                if (RX_ER) flag_er <= 1'b1;
                if (RX_DV) begin
                    if (byte_cnt < LEN_MAX) begin
                        byte_cnt <= byte_cnt + SLOT_ADDR_W'(1);
                        if (byte_cnt < SLOT_ADDR_W'(6)) dest <= {dest[39:0], RXD};
                    end else begin
                        flag_long <= 1'b1;
                    end
                end
            end
            if (overflow_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            if (commit_ok)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_release) rd_ptr <= rd_ptr + PTR_W'(1);
            if (commit_ok && !do_release)      count <= count + CNT_W'(1);
            else if (!commit_ok && do_release) count <= count - CNT_W'(1);
        end
    end

`ifdef VTHERNET_RX_CRC_CHECK_EN
    logic [31:0] crc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Running over the FCS as well leaves the fixed residue when the frame is intact.
    always_ff @(posedge clk) begin
        if (rst || start_frame)          crc <= '1;
        else if (state == S_DATA && RX_DV) crc <= crc_byte(crc, RXD);
    end

    assign crc_err = (crc != 32'hDEBB20E3);
`else
    assign crc_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (state == S_DATA && RX_DV && byte_cnt < LEN_MAX) mem[{wr_ptr, byte_cnt}] <= RXD;
    end

    always_ff @(posedge clk) begin
        if (rst)                rd_data <= '0;
        else if (frame_pending) rd_data <= mem[{rd_ptr, rd_addr}];
        else                    rd_data <= '0;
    end

    always_ff @(posedge clk) begin
        if (commit_ok) begin
            meta_len[wr_ptr]    <= byte_cnt;
            meta_status[wr_ptr] <= status_now;
        end
    end

    assign head_len    = frame_pending ? meta_len[rd_ptr]    : '0;
    assign head_status = frame_pending ? meta_status[rd_ptr] : '0;
endmodule
